bin2seg_conv: RTL

//  Parametrised successor to the fixed 8-bit hex-to-BCD encoders. Converts a BIN_W-bit unsigned binary value
//  (clock/timer/amplitude readout) to DIGITS packed BCD digits with a sequential double-dabble engine,
//  one shift per clock. Registers 7-segment patterns for the display port. Uses a valid/ready handshake on

---
 rtl/bin2seg_pkg.sv | 25 ++
 rtl/bin2seg_conv_seg7_enc.sv | 12 +
 rtl/bin2seg_conv.sv | 100 ++++++++++
 3 files changed

// File: rtl/bin2seg_pkg.sv
// bin2seg_pkg: shared FSM state type, blank pattern and BCD digit to 7-segment lookup.
package bin2seg_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}, active-high; non-decimal codes render blank.
    function automatic logic [6:0] seg7_code(input logic [3:0] d);
        case (d)
            4'd0:    seg7_code = 7'h3F;
            4'd1:    seg7_code = 7'h06;
            4'd2:    seg7_code = 7'h5B;
            4'd3:    seg7_code = 7'h4F;
            4'd4:    seg7_code = 7'h66;
            4'd5:    seg7_code = 7'h6D;
            4'd6:    seg7_code = 7'h7D;
            4'd7:    seg7_code = 7'h07;
            4'd8:    seg7_code = 7'h7F;
            4'd9:    seg7_code = 7'h6F;
            default: seg7_code = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2seg_conv_seg7_enc.sv
// seg7_enc: combinational BCD digit to 7-segment pattern with a blank override.
module seg7_enc
    import bin2seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg7_code(digit);

endmodule

// File: rtl/bin2seg_conv.sv
// bin2seg_conv: sequential double-dabble binary to BCD converter with registered 7-segment outputs.
// Optional leading-zero blanking of the segment outputs when LZ_BLANK_EN is defined.
module bin2seg_conv
    import bin2seg_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [DIGITS*7-1:0]   seg
);

    localparam int CW = $clog2(BIN_W + 1);

    if (BIN_W < 4 || BIN_W > 32) begin : g_width_chk
        $error("bin2seg_conv: BIN_W must be within 4..32");
    end
    if (64'd10 ** DIGITS <= (64'd1 << BIN_W) - 64'd1) begin : g_digits_chk
        $error("bin2seg_conv: DIGITS too small to hold 2**BIN_W-1");
    end

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic [DIGITS*4-1:0]   acc_q, acc_d, adj;
    logic [DIGITS*4-1:0]   bcd_q, bcd_d;
    logic [DIGITS*7-1:0]   seg_q, seg_d, seg_w;
    logic [DIGITS-1:0]     blank;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
`ifdef LZ_BLANK_EN
        assign blank[i] = (i != 0) && (acc_q[DIGITS*4-1:i*4] == '0);
`else
        assign blank[i] = 1'b0;
`endif
        seg7_enc u_enc (.digit(acc_q[4*i+:4]), .blank(blank[i]), .seg(seg_w[7*i+:7]));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        seg_d   = seg_q;
        adj     = acc_q;
        for (int i = 0; i < DIGITS; i++)
            if (acc_q[4*i+:4] >= 4'd5) adj[4*i+:4] = acc_q[4*i+:4] + 4'd3;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = SHIFT;
                bin_d   = in_data;
                acc_d   = '0;
                cnt_d   = '0;
            end
            // The extra cycle after the last shift publishes the finished accumulator.
            SHIFT: if (cnt_q == CW'(BIN_W)) begin
                bcd_d   = acc_q;
                seg_d   = seg_w;
                state_d = DONE;
            end else begin
                {acc_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q + CW'(1);
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            seg_q   <= seg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;
    assign seg       = seg_q;

endmodule
